// File: rtl/id_exe_skid_reg.sv
// rtl/id_exe_skid_reg.sv - two-entry elastic decode-to-execute pipeline register with flush
module id_exe_skid_reg #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 12,
    parameter int IMM24_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_pc,
    input  logic [DATA_WIDTH-1:0]  in_val_rn,
    input  logic [DATA_WIDTH-1:0]  in_val_rm,
    input  logic [SHIFT_WIDTH-1:0] in_shift_operand,
    input  logic                   in_imm,
    input  logic [IMM24_WIDTH-1:0] in_imm24,
    input  logic [3:0]             in_dest,
    input  logic [3:0]             in_exe_cmd,
    input  logic                   in_mem_r_en,
    input  logic                   in_mem_w_en,
    input  logic                   in_wb_en,
    input  logic                   in_b,
    input  logic                   in_s,
    input  logic [3:0]             in_sr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_pc,
    output logic [DATA_WIDTH-1:0]  out_val_rn,
    output logic [DATA_WIDTH-1:0]  out_val_rm,
    output logic [SHIFT_WIDTH-1:0] out_shift_operand,
    output logic                   out_imm,
    output logic [IMM24_WIDTH-1:0] out_imm24,
    output logic [3:0]             out_dest,
    output logic [3:0]             out_exe_cmd,
    output logic                   out_mem_r_en,
    output logic                   out_mem_w_en,
    output logic                   out_wb_en,
    output logic                   out_b,
    output logic                   out_s,
    output logic [3:0]             out_sr,
    output logic                   out_mem_access
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  pc;
        logic [DATA_WIDTH-1:0]  val_rn;
        logic [DATA_WIDTH-1:0]  val_rm;
        logic [SHIFT_WIDTH-1:0] shift_operand;
        logic                   imm;
        logic [IMM24_WIDTH-1:0] imm24;
        logic [3:0]             dest;
        logic [3:0]             exe_cmd;
        logic                   mem_r_en;
        logic                   mem_w_en;
        logic                   wb_en;
        logic                   b;
        logic                   s;
        logic [3:0]             sr;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t  state, state_next;
    bundle_t in_bundle, main_q, skid_q;
    logic    mem_access_q;
    logic    accept, consume;
    logic    main_load_in, main_load_skid, skid_load, clear_ctrl;

    always_comb begin
        in_bundle               = '0;
        in_bundle.pc            = in_pc;
        in_bundle.val_rn        = in_val_rn;
        in_bundle.val_rm        = in_val_rm;
        in_bundle.shift_operand = in_shift_operand;
        in_bundle.imm           = in_imm;
        in_bundle.imm24         = in_imm24;
        in_bundle.dest          = in_dest;
        in_bundle.exe_cmd       = in_exe_cmd;
        in_bundle.mem_r_en      = in_mem_r_en;
        in_bundle.mem_w_en      = in_mem_w_en;
        in_bundle.wb_en         = in_wb_en;
        in_bundle.b             = in_b;
        in_bundle.s             = in_s;
        in_bundle.sr            = in_sr;
    end

    // in_ready and out_valid decode straight from the state flops, so no path from out_ready
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_next     = state;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        clear_ctrl     = 1'b0;
        if (flush) begin
            state_next = EMPTY;
            clear_ctrl = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next   = ONE;
                        main_load_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_load_in = 1'b1;
                    end else if (accept) begin
                        state_next = TWO;
                        skid_load  = 1'b1;
                    end else if (consume) begin
                        state_next = EMPTY;
                        clear_ctrl = 1'b1;
                    end
                end
                TWO: begin
                    if (consume) begin
                        state_next     = ONE;
                        main_load_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    clear_ctrl = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Data fields hold when the register empties; only the side-effecting controls are cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            mem_access_q <= 1'b0;
        end else begin
            if (main_load_in) begin
                main_q       <= in_bundle;
                mem_access_q <= in_mem_r_en | in_mem_w_en;
            end else if (main_load_skid) begin
                main_q       <= skid_q;
                mem_access_q <= skid_q.mem_r_en | skid_q.mem_w_en;
            end else if (clear_ctrl) begin
                main_q.mem_r_en <= 1'b0;
                main_q.mem_w_en <= 1'b0;
                main_q.wb_en    <= 1'b0;
                main_q.b        <= 1'b0;
                main_q.s        <= 1'b0;
                mem_access_q    <= 1'b0;
            end
            if (skid_load) begin
                skid_q <= in_bundle;
            end
        end
    end

    assign out_pc            = main_q.pc;
    assign out_val_rn        = main_q.val_rn;
    assign out_val_rm        = main_q.val_rm;
    assign out_shift_operand = main_q.shift_operand;
    assign out_imm           = main_q.imm;
    assign out_imm24         = main_q.imm24;
    assign out_dest          = main_q.dest;
    assign out_exe_cmd       = main_q.exe_cmd;
    assign out_mem_r_en      = main_q.mem_r_en;
    assign out_mem_w_en      = main_q.mem_w_en;
    assign out_wb_en         = main_q.wb_en;
    assign out_b             = main_q.b;
    assign out_s             = main_q.s;
    assign out_sr            = main_q.sr;
    assign out_mem_access    = mem_access_q;

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// tb/tb_id_exe_skid_reg.sv - table-driven bench for id_exe_skid_reg
module tb_id_exe_skid_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0, in_val_rn = '0, in_val_rm = '0;
    logic [11:0] in_shift_operand = '0;
    logic        in_imm = 1'b0;
    logic [23:0] in_imm24 = '0;
    logic [3:0]  in_dest = '0, in_exe_cmd = '0, in_sr = '0;
    logic        in_mem_r_en = 1'b0, in_mem_w_en = 1'b0, in_wb_en = 1'b0, in_b = 1'b0, in_s = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_val_rn, out_val_rm;
    logic [11:0] out_shift_operand;
    logic        out_imm;
    logic [23:0] out_imm24;
    logic [3:0]  out_dest, out_exe_cmd, out_sr;
    logic        out_mem_r_en, out_mem_w_en, out_wb_en, out_b, out_s, out_mem_access;

    int tests = 0;
    int fails = 0;

    id_exe_skid_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_val_rn(in_val_rn), .in_val_rm(in_val_rm),
        .in_shift_operand(in_shift_operand), .in_imm(in_imm), .in_imm24(in_imm24),
        .in_dest(in_dest), .in_exe_cmd(in_exe_cmd),
        .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en), .in_wb_en(in_wb_en),
        .in_b(in_b), .in_s(in_s), .in_sr(in_sr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_val_rn(out_val_rn), .out_val_rm(out_val_rm),
        .out_shift_operand(out_shift_operand), .out_imm(out_imm), .out_imm24(out_imm24),
        .out_dest(out_dest), .out_exe_cmd(out_exe_cmd),
        .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en), .out_wb_en(out_wb_en),
        .out_b(out_b), .out_s(out_s), .out_sr(out_sr),
        .out_mem_access(out_mem_access)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, iv, ordy, mr, mw, wb;
        logic [31:0] pc;
        logic        ov, ir, owb, omw, oma;
        logic [31:0] opc;
    } vec_t;

    vec_t vecs[$];

    // Secondary fields are derived from pc so one expected pc pins the whole bundle
    function automatic logic [31:0] rm_of(input logic [31:0] pc);
        return pc ^ 32'h0000_00E0;
    endfunction
    function automatic logic [11:0] sh_of(input logic [31:0] pc);
        return pc[11:0] ^ 12'h0B3;
    endfunction
    function automatic logic [23:0] i24_of(input logic [31:0] pc);
        return pc[23:0] + 24'h80_0001;
    endfunction
    function automatic logic [3:0] dst_of(input logic [31:0] pc);
        return pc[5:2];
    endfunction

    task automatic add(input logic fl, iv, ordy, mr, mw, wb, input logic [31:0] pc,
                       input logic ov, ir, owb, omw, oma, input logic [31:0] opc);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.mr = mr; v.mw = mw; v.wb = wb; v.pc = pc;
        v.ov = ov; v.ir = ir; v.owb = owb; v.omw = omw; v.oma = oma; v.opc = opc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, iv, ordy, mr, mw, wb, input logic [31:0] pc);
        flush = fl; in_valid = iv; out_ready = ordy;
        in_mem_r_en = mr; in_mem_w_en = mw; in_wb_en = wb;
        in_pc = pc; in_val_rn = ~pc; in_val_rm = rm_of(pc);
        in_shift_operand = sh_of(pc); in_imm24 = i24_of(pc); in_dest = dst_of(pc);
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.ov));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.ir));
        chk({tag, ".out_wb_en"}, 32'(out_wb_en), 32'(v.owb));
        chk({tag, ".out_mem_w_en"}, 32'(out_mem_w_en), 32'(v.omw));
        chk({tag, ".out_mem_access"}, 32'(out_mem_access), 32'(v.oma));
        if (v.ov) begin
            chk({tag, ".out_pc"}, out_pc, v.opc);
            chk({tag, ".out_val_rn"}, out_val_rn, ~v.opc);
            chk({tag, ".out_val_rm"}, out_val_rm, rm_of(v.opc));
            chk({tag, ".out_shift"}, 32'(out_shift_operand), 32'(sh_of(v.opc)));
            chk({tag, ".out_imm24"}, 32'(out_imm24), 32'(i24_of(v.opc)));
            chk({tag, ".out_dest"}, 32'(out_dest), 32'(dst_of(v.opc)));
        end
    endtask

    initial begin
        vec_t rv;
        // fl iv rdy mr mw wb pc        ov ir wb mw ma opc
        add(0, 1, 1, 0, 0, 1, 32'h10,   1, 1, 1, 0, 0, 32'h10);
        add(0, 0, 1, 0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 32'h10);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 1, 0, 0, 1, 32'(4*k), 1, 1, 1, 0, 0, 32'(4*k));
        add(0, 0, 1, 0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 32'h20);
        add(0, 1, 0, 0, 0, 1, 32'h20,   1, 1, 1, 0, 0, 32'h20);
        add(0, 1, 0, 0, 0, 1, 32'h24,   1, 0, 1, 0, 0, 32'h20);
        add(0, 0, 0, 0, 0, 0, 32'h0,    1, 0, 1, 0, 0, 32'h20);
        add(0, 1, 1, 0, 0, 1, 32'h28,   1, 1, 1, 0, 0, 32'h24);
        add(0, 0, 1, 0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 32'h24);
        add(0, 1, 0, 1, 0, 1, 32'h30,   1, 1, 1, 0, 1, 32'h30);
        add(0, 1, 0, 0, 1, 0, 32'h34,   1, 0, 1, 0, 1, 32'h30);
        add(1, 1, 0, 0, 1, 1, 32'h38,   0, 1, 0, 0, 0, 32'h0);
        add(0, 0, 1, 0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 32'h0);
        add(0, 1, 0, 1, 0, 0, 32'h40,   1, 1, 0, 0, 1, 32'h40);
        add(0, 0, 0, 0, 0, 0, 32'h0,    1, 1, 0, 0, 1, 32'h40);
        add(0, 0, 1, 0, 0, 0, 32'h0,    0, 1, 0, 0, 0, 32'h40);
        add(0, 1, 1, 0, 1, 1, 32'h44,   1, 1, 1, 1, 1, 32'h44);
        add(1, 1, 1, 0, 1, 1, 32'h48,   0, 1, 0, 0, 0, 32'h0);
        add(0, 1, 1, 0, 0, 1, 32'h4C,   1, 1, 1, 0, 0, 32'h4C);

        #2;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_pc", out_pc, 32'd0);
        chk("reset.out_wb_en", 32'(out_wb_en), 32'd0);
        chk("reset.out_mem_access", 32'(out_mem_access), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].mr, vecs[i].mw, vecs[i].wb, vecs[i].pc);
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Async reset mid-cycle while ONE holds 0x4C: outputs drop before any clock edge
        drive(0, 1, 0, 1, 1, 1, 32'h50);
        #3 rst = 1'b1;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.out_wb_en", 32'(out_wb_en), 32'd0);
        chk("arst.out_mem_access", 32'(out_mem_access), 32'd0);
        chk("arst.out_mem_r_en", 32'(out_mem_r_en), 32'd0);
        @(posedge clk); #1;
        chk("arst_hold.out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        #1;
        chk("arst_rel.in_ready", 32'(in_ready), 32'd1);
        drive(0, 1, 0, 0, 0, 1, 32'h54);
        @(posedge clk); #1;
        rv.ov = 1; rv.ir = 1; rv.owb = 1; rv.omw = 0; rv.oma = 0; rv.opc = 32'h54;
        rv.fl = 0; rv.iv = 0; rv.ordy = 0; rv.mr = 0; rv.mw = 0; rv.wb = 0; rv.pc = 0;
        check_outputs("post_rst", rv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
